// File: rtl/control.sv
// control: multi-cycle MIPS-subset main control FSM (Moore outputs plus funct/op decode).
// Optional OVF_GUARD_EN suppresses register writes for signed-overflowing add/sub/addi.
module control (
   input  logic        clk,
   input  logic        rst,
   input  logic        MIO_ready,
   input  logic        zero,
   input  logic        overflow,
   input  logic [31:0] inst,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IorD,
   output logic        CPU_MIO,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        Branch,
   output logic [1:0]  RegDst,
   output logic [1:0]  MemtoReg,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [2:0]  ALU_operation,
   output logic [4:0]  state_out
);
   typedef enum logic [3:0] {
      S_IF, S_ID, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXE, S_R_WB,
      S_BRANCH, S_JUMP, S_I_EXE, S_I_WB, S_LUI, S_JR, S_JAL, S_ERROR
   } state_t;
   localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011,
                          ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
   state_t state_q, state_d;
   logic [5:0] op, funct;
   logic [2:0] r_alu, i_alu;
   logic reg_write_raw, pc_write_raw, pc_write_cond_raw, ir_write_raw, mem_write_raw;
   logic unused;
   assign op = inst[31:26];
   assign funct = inst[5:0];
   // zero is consumed by the datapath's branch gate, not by the sequencer
   assign unused = ^{zero, overflow, inst[25:6]};
   assign state_out = {1'b0, state_q};
   always_comb begin
      r_alu = ALU_ADD;
      case (funct)
         6'b100010: r_alu = ALU_SUB;
         6'b100100: r_alu = ALU_AND;
         6'b100101: r_alu = ALU_OR;
         6'b100110: r_alu = ALU_XOR;
         6'b100111: r_alu = ALU_NOR;
         6'b101010: r_alu = ALU_SLT;
         6'b000010: r_alu = ALU_SRL;
         default:   r_alu = ALU_ADD;
      endcase
   end
   always_comb begin
      i_alu = ALU_ADD;
      case (op)
         6'b001100: i_alu = ALU_AND;
         6'b001101: i_alu = ALU_OR;
         6'b001110: i_alu = ALU_XOR;
         6'b001010: i_alu = ALU_SLT;
         default:   i_alu = ALU_ADD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:      state_d = MIO_ready ? S_ID : S_IF;
         S_ID: begin
            case (op)
               6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_R_EXE;
               6'b100011, 6'b101011: state_d = S_MEM_ADR;
               6'b000100, 6'b000101: state_d = S_BRANCH;
               6'b000010: state_d = S_JUMP;
               6'b000011: state_d = S_JAL;
               6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: state_d = S_I_EXE;
               6'b001111: state_d = S_LUI;
               default:   state_d = S_ERROR;
            endcase
         end
         S_MEM_ADR: state_d = (op == 6'b101011) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  state_d = MIO_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:  state_d = MIO_ready ? S_IF : S_MEM_WR;
         S_R_EXE:   state_d = S_R_WB;
         S_I_EXE:   state_d = S_I_WB;
         default:   state_d = S_IF;
      endcase
   end
   always_comb begin
      MemRead = 1'b0;
      mem_write_raw = 1'b0;
      IorD = 1'b0;
      CPU_MIO = 1'b0;
      ir_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      ALUSrcA = 1'b0;
      pc_write_raw = 1'b0;
      pc_write_cond_raw = 1'b0;
      Branch = 1'b0;
      RegDst = 2'b00;
      MemtoReg = 2'b00;
      ALUSrcB = 2'b00;
      PCSource = 2'b00;
      ALU_operation = ALU_AND;
      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            CPU_MIO = 1'b1;
            ALUSrcB = 2'b01;
            ALU_operation = ALU_ADD;
            ir_write_raw = MIO_ready;
            pc_write_raw = MIO_ready;
         end
         S_ID: begin
            ALUSrcB = 2'b11;
            ALU_operation = ALU_ADD;
         end
         S_MEM_ADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALU_operation = ALU_ADD;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            CPU_MIO = 1'b1;
            IorD = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_raw = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEM_WR: begin
            mem_write_raw = 1'b1;
            CPU_MIO = 1'b1;
            IorD = 1'b1;
         end
         S_R_EXE: begin
            ALUSrcA = 1'b1;
            ALU_operation = r_alu;
         end
         S_R_WB: begin
            RegDst = 2'b01;
`ifdef OVF_GUARD_EN
            reg_write_raw = !(overflow && (funct == 6'b100000 || funct == 6'b100010));
`else
            reg_write_raw = 1'b1;
`endif
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALU_operation = ALU_SUB;
            pc_write_cond_raw = 1'b1;
            PCSource = 2'b01;
            Branch = (op == 6'b000100);
         end
         S_JUMP: begin
            pc_write_raw = 1'b1;
            PCSource = 2'b10;
         end
         S_JAL: begin
            reg_write_raw = 1'b1;
            RegDst = 2'b10;
            MemtoReg = 2'b11;
            pc_write_raw = 1'b1;
            PCSource = 2'b10;
         end
         S_JR: begin
            pc_write_raw = 1'b1;
            PCSource = 2'b11;
         end
         S_I_EXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALU_operation = i_alu;
         end
         S_I_WB: begin
`ifdef OVF_GUARD_EN
            reg_write_raw = !(overflow && op == 6'b001000);
`else
            reg_write_raw = 1'b1;
`endif
         end
         S_LUI: begin
            reg_write_raw = 1'b1;
            MemtoReg = 2'b10;
         end
         default: begin
         end
      endcase
   end
   // reset masks every architectural write so an aborted instruction leaves no trace
   assign PCWrite = pc_write_raw & ~rst;
   assign PCWriteCond = pc_write_cond_raw & ~rst;
   assign IRWrite = ir_write_raw & ~rst;
   assign RegWrite = reg_write_raw & ~rst;
   assign MemWrite = mem_write_raw & ~rst;
endmodule

// File: tb/tb_control.sv
// tb_control: directed-step bench for the multi-cycle control FSM.
module tb_control;
   logic clk = 1'b0, rst = 1'b1, MIO_ready = 1'b0, zero = 1'b0, overflow = 1'b0;
   logic [31:0] inst = 32'h0;
   logic MemRead, MemWrite, IorD, CPU_MIO, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic [2:0] ALU_operation;
   logic [4:0] state_out;
   int total = 0, bad = 0;
   control dut (
      .clk(clk), .rst(rst), .MIO_ready(MIO_ready), .zero(zero), .overflow(overflow), .inst(inst),
      .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .CPU_MIO(CPU_MIO), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALU_operation(ALU_operation), .state_out(state_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic step(input logic [4:0] s);
      tick();
      chk("state", {27'h0, state_out}, {27'h0, s});
   endtask
   task automatic no_writes(input string tag);
      chk(tag, {27'h0, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite}, 32'h0);
   endtask
   initial begin
      // reset
      tick();
      chk("rst_state", {27'h0, state_out}, 32'd0);
      no_writes("rst_writes");
      MIO_ready = 1'b1;
      #1;
      no_writes("rst_mask_ready");
      chk("rst_memread", {31'h0, MemRead}, 32'd1);
      MIO_ready = 1'b0;
      rst = 1'b0;
      step(5'd0);
      step(5'd0);
      // addi
      inst = 32'h20100000;
      MIO_ready = 1'b1;
      #1;
      chk("if_pcw_irw", {30'h0, PCWrite, IRWrite}, 32'h3);
      chk("if_mem", {29'h0, MemRead, CPU_MIO, IorD}, 32'h6);
      chk("if_alu", {27'h0, ALUSrcA, ALUSrcB, ALU_operation}, {27'h0, 1'b0, 2'b01, 3'b010});
      step(5'd1);
      chk("id_alu", {27'h0, ALUSrcA, ALUSrcB, ALU_operation}, {27'h0, 1'b0, 2'b11, 3'b010});
      no_writes("id_writes");
      step(5'd10);
      chk("iexe_alu", {27'h0, ALUSrcA, ALUSrcB, ALU_operation}, {27'h0, 1'b1, 2'b10, 3'b010});
      step(5'd11);
      chk("iwb", {29'h0, RegWrite, RegDst}, 32'h4);
      overflow = 1'b1;
      #1;
`ifdef OVF_GUARD_EN
      chk("iwb_ovf", {31'h0, RegWrite}, 32'd0);
`else
      chk("iwb_ovf", {31'h0, RegWrite}, 32'd1);
`endif
      overflow = 1'b0;
      step(5'd0);
      // ori -> or
      inst = 32'h34100001;
      step(5'd1);
      step(5'd10);
      chk("ori_alu", {29'h0, ALU_operation}, 32'd1);
      step(5'd11);
      step(5'd0);
      // lw with 3 stall cycles
      inst = 32'h8C100004;
      step(5'd1);
      step(5'd2);
      chk("memadr", {27'h0, ALUSrcA, ALUSrcB, ALU_operation}, {27'h0, 1'b1, 2'b10, 3'b010});
      MIO_ready = 1'b0;
      step(5'd3);
      chk("memrd", {29'h0, MemRead, IorD, CPU_MIO}, 32'h7);
      step(5'd3);
      step(5'd3);
      chk("memrd_stall", {29'h0, MemRead, IorD, CPU_MIO}, 32'h7);
      step(5'd3);
      MIO_ready = 1'b1;
      step(5'd4);
      chk("memwb", {27'h0, RegWrite, RegDst, MemtoReg}, {27'h0, 1'b1, 2'b00, 2'b01});
      step(5'd0);
      // sw
      inst = 32'hAC100004;
      step(5'd1);
      step(5'd2);
      step(5'd5);
      chk("memwr", {28'h0, MemWrite, CPU_MIO, IorD, MemRead}, 32'hE);
      step(5'd0);
      // beq / bne
      inst = 32'h10000003;
      step(5'd1);
      step(5'd8);
      chk("beq", {25'h0, PCWriteCond, Branch, PCSource, ALU_operation}, {25'h0, 1'b1, 1'b1, 2'b01, 3'b110});
      step(5'd0);
      inst = 32'h14000003;
      step(5'd1);
      step(5'd8);
      chk("bne", {25'h0, PCWriteCond, Branch, PCSource, ALU_operation}, {25'h0, 1'b1, 1'b0, 2'b01, 3'b110});
      step(5'd0);
      // R-type sub
      inst = 32'h02118022;
      step(5'd1);
      step(5'd6);
      chk("rexe", {27'h0, ALUSrcA, ALUSrcB, ALU_operation}, {27'h0, 1'b1, 2'b00, 3'b110});
      step(5'd7);
      chk("rwb", {27'h0, RegWrite, RegDst, MemtoReg}, {27'h0, 1'b1, 2'b01, 2'b00});
      step(5'd0);
      // R-type slt with overflow flag ignored for non-add/sub
      inst = 32'h0211802A;
      step(5'd1);
      step(5'd6);
      chk("slt_alu", {29'h0, ALU_operation}, 32'd7);
      step(5'd7);
      overflow = 1'b1;
      #1;
      chk("slt_ovf", {31'h0, RegWrite}, 32'd1);
      overflow = 1'b0;
      step(5'd0);
      // jal
      inst = 32'h0C000010;
      step(5'd1);
      step(5'd14);
      chk("jal", {24'h0, PCWrite, RegWrite, RegDst, MemtoReg, PCSource}, {24'h0, 1'b1, 1'b1, 2'b10, 2'b11, 2'b10});
      step(5'd0);
      // j, jr, lui
      inst = 32'h08000000;
      step(5'd1);
      step(5'd9);
      chk("j", {29'h0, PCWrite, PCSource}, 32'h6);
      step(5'd0);
      inst = 32'h03E00008;
      step(5'd1);
      step(5'd13);
      chk("jr", {29'h0, PCWrite, PCSource}, 32'h7);
      step(5'd0);
      inst = 32'h3C101234;
      step(5'd1);
      step(5'd12);
      chk("lui", {27'h0, RegWrite, RegDst, MemtoReg}, {27'h0, 1'b1, 2'b00, 2'b10});
      step(5'd0);
      // illegal opcode
      inst = 32'h5B000004;
      step(5'd1);
      step(5'd15);
      no_writes("err_writes");
      step(5'd0);
      // reset mid-instruction
      inst = 32'h02118022;
      step(5'd1);
      step(5'd6);
      rst = 1'b1;
      step(5'd0);
      no_writes("rst_abort");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
